// File: rtl/ip_codma_task_sched.sv
// Task scheduler in front of a codma engine: queues {task,status} pointer pairs
// and launches them one at a time, supervising start, completion, abort and start timeout.
module ip_codma_task_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [31:0]                push_task_ptr_i,
  input  logic [31:0]                push_status_ptr_i,
  input  logic                       enable_i,
  input  logic                       abort_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       codma_start_o,
  output logic                       codma_stop_o,
  output logic [31:0]                codma_task_ptr_o,
  output logic [31:0]                codma_status_ptr_o,
  input  logic                       codma_busy_i,
  input  logic                       codma_irq_i,
  output logic                       done_o,
  output logic [15:0]                done_count_o,
  output logic                       drained_o,
  output logic                       overflow_o,
  output logic                       error_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshake: push_i is a single-cycle request with no ready; a push that cannot be
  // taken is dropped and recorded in overflow_o. codma_start_o is a one-cycle strobe;
  // the codma acknowledges by raising codma_busy_i and completes via codma_irq_i or by
  // dropping codma_busy_i.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN,
    S_STOPPING,
    S_ERROR
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]   task_mem   [DEPTH];
  logic [31:0]   status_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] wait_cnt;
  logic [15:0]   done_count;
  logic          overflow;
  logic          pop;
  logic          is_full;
  logic          push_acc;
  logic          push_drop;
  logic          load_head;
  logic          done;
  logic          timeout_hit;

  assign pop         = (state == S_LAUNCH);
  assign is_full     = (count == CW'(DEPTH));
  // A full queue still accepts a push in the launch cycle because the head leaves then.
  assign push_acc    = push_i && !abort_i && (!is_full || pop);
  assign push_drop   = push_i && !abort_i && !push_acc;
  assign load_head   = (state == S_IDLE) && (state_next == S_LAUNCH);
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable_i && (count != '0) && !abort_i) state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_next = abort_i ? S_STOPPING : S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (abort_i)           state_next = S_STOPPING;
        else if (codma_busy_i) state_next = S_RUN;
        else if (timeout_hit)  state_next = S_ERROR;
      end
      S_RUN: begin
        if (abort_i) begin
          state_next = S_STOPPING;
        end else if (codma_irq_i || !codma_busy_i) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_STOPPING: begin
        if (!codma_busy_i) state_next = S_IDLE;
      end
      S_ERROR: begin
        if (abort_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      task_mem[wr_ptr]   <= push_task_ptr_i;
      status_mem[wr_ptr] <= push_status_ptr_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      codma_task_ptr_o   <= '0;
      codma_status_ptr_o <= '0;
    end else if (load_head) begin
      codma_task_ptr_o   <= task_mem[rd_ptr];
      codma_status_ptr_o <= status_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT_BUSY) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      done_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (done)      done_count <= done_count + 16'd1;
      if (push_drop) overflow   <= 1'b1;
    end
  end

  assign full_o        = is_full;
  assign count_o       = count;
  assign codma_start_o = (state == S_LAUNCH);
  assign codma_stop_o  = (state == S_STOPPING);
  assign error_o       = (state == S_ERROR);
  assign done_o        = done;
  assign drained_o     = done && (count == '0);
  assign done_count_o  = done_count;
  assign overflow_o    = overflow;

endmodule

// File: tb/tb_ip_codma_task_sched.sv
// Randomized bench for ip_codma_task_sched: a queue-based model of the task list,
// completion counter and sticky flags predicts every observed output.
module tb_ip_codma_task_sched;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          push_i;
  logic [31:0]   push_task_ptr_i;
  logic [31:0]   push_status_ptr_i;
  logic          enable_i;
  logic          abort_i;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          codma_start_o;
  logic          codma_stop_o;
  logic [31:0]   codma_task_ptr_o;
  logic [31:0]   codma_status_ptr_o;
  logic          codma_busy_i;
  logic          codma_irq_i;
  logic          done_o;
  logic [15:0]   done_count_o;
  logic          drained_o;
  logic          overflow_o;
  logic          error_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [15:0] exp_done_count;
  logic        exp_overflow;

  int cyc = 0;
  int last_start = -100;

  ip_codma_task_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .push_i             (push_i),
    .push_task_ptr_i    (push_task_ptr_i),
    .push_status_ptr_i  (push_status_ptr_i),
    .enable_i           (enable_i),
    .abort_i            (abort_i),
    .full_o             (full_o),
    .count_o            (count_o),
    .codma_start_o      (codma_start_o),
    .codma_stop_o       (codma_stop_o),
    .codma_task_ptr_o   (codma_task_ptr_o),
    .codma_status_ptr_o (codma_status_ptr_o),
    .codma_busy_i       (codma_busy_i),
    .codma_irq_i        (codma_irq_i),
    .done_o             (done_o),
    .done_count_o       (done_count_o),
    .drained_o          (drained_o),
    .overflow_o         (overflow_o),
    .error_o            (error_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Start strobes must be at least 3 cycles apart.
  always @(negedge clk_i) begin
    if (reset_i) begin
      last_start = -100;
    end else if (codma_start_o === 1'b1) begin
      checks++;
      if (cyc - last_start < 3) begin
        errors++;
        $display("FAIL start_spacing: got %0d cycles, required >= 3", cyc - last_start);
      end
      last_start = cyc;
    end
  end

  // Driver tasks
  task automatic do_reset();
    reset_i           = 1'b1;
    push_i            = 1'b0;
    push_task_ptr_i   = '0;
    push_status_ptr_i = '0;
    enable_i          = 1'b0;
    abort_i           = 1'b0;
    codma_busy_i      = 1'b0;
    codma_irq_i       = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    exp_q.delete();
    exp_done_count = '0;
    exp_overflow   = 1'b0;
  endtask

  task automatic push_task(input logic [31:0] t, input logic [31:0] s);
    push_i            = 1'b1;
    push_task_ptr_i   = t;
    push_status_ptr_i = s;
    @(posedge clk_i);
    #1 push_i = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back({t, s});
    else exp_overflow = 1'b1;
  endtask

  task automatic check_launch(output bit ok);
    bit seen;
    logic [63:0] e;
    ok   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (codma_start_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL start_wait: no codma_start_o within 20 cycles, required 1");
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL start_empty: start issued, required no start (model queue empty)");
      return;
    end
    e = exp_q.pop_front();
    if ({codma_task_ptr_o, codma_status_ptr_o} !== e) begin
      errors++;
      $display("FAIL launch_ptrs: got %h/%h required %h/%h",
               codma_task_ptr_o, codma_status_ptr_o, e[63:32], e[31:0]);
    end
    ok = 1'b1;
  endtask

  task automatic run_task(input int busy_cycles, input bit by_irq);
    bit ok;
    logic [CW-1:0] ec;
    check_launch(ok);
    if (!ok) return;
    @(posedge clk_i);
    #1 codma_busy_i = 1'b1;
    for (int i = 0; i < busy_cycles; i++) begin
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0) begin
        errors++;
        $display("FAIL early_done: got %b required 0", done_o);
      end
      @(posedge clk_i);
      #1;
    end
    if (by_irq) codma_irq_i = 1'b1;
    else codma_busy_i = 1'b0;
    @(negedge clk_i);
    exp_done_count = exp_done_count + 16'd1;
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: got %b required 1", done_o);
    end
    checks++;
    if (drained_o !== (exp_q.size() == 0)) begin
      errors++;
      $display("FAIL drained: got %b required %b", drained_o, exp_q.size() == 0);
    end
    @(posedge clk_i);
    #1;
    codma_irq_i  = 1'b0;
    codma_busy_i = 1'b0;
    @(negedge clk_i);
    ec = CW'(exp_q.size());
    checks++;
    if (done_count_o !== exp_done_count) begin
      errors++;
      $display("FAIL done_count: got %0d required %0d", done_count_o, exp_done_count);
    end
    checks++;
    if (count_o !== ec) begin
      errors++;
      $display("FAIL count_after_task: got %0d required %0d", count_o, ec);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    checks++;
    if ({count_o, full_o, codma_start_o, codma_stop_o, codma_task_ptr_o, codma_status_ptr_o,
         done_o, done_count_o, drained_o, overflow_o, error_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero (count=%0d err=%b ovf=%b) required all 0",
               count_o, error_o, overflow_o);
    end
  endtask

  task automatic test_basic();
    do_reset();
    push_task(32'h100, 32'h200);
    push_task(32'h300, 32'h400);
    @(negedge clk_i);
    checks++;
    if (count_o !== CW'(2)) begin
      errors++;
      $display("FAIL basic_count: got %0d required 2", count_o);
    end
    @(posedge clk_i);
    #1 enable_i = 1'b1;
    run_task(5, 1'b1);
    run_task(5, 1'b1);
    repeat (4) begin
      @(negedge clk_i);
      checks++;
      if (codma_start_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_idle_start: got %b required 0", codma_start_o);
      end
    end
    enable_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [CW-1:0] ec;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) push_task($urandom, $urandom);
    @(negedge clk_i);
    ec = CW'(exp_q.size());
    checks++;
    if (count_o !== ec || full_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_count: got count=%0d full=%b required %0d/1", count_o, full_o, ec);
    end
    checks++;
    if (overflow_o !== exp_overflow) begin
      errors++;
      $display("FAIL ovf_flag: got %b required %b", overflow_o, exp_overflow);
    end
    @(posedge clk_i);
    #1 enable_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) run_task(2, 1'b1);
    enable_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required 1", overflow_o);
    end
  endtask

  task automatic test_push_in_launch();
    bit ok;
    logic [31:0] t;
    logic [31:0] s;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_task($urandom, $urandom);
    enable_i = 1'b1;
    check_launch(ok);
    if (!ok) return;
    t = $urandom;
    s = $urandom;
    push_i            = 1'b1;
    push_task_ptr_i   = t;
    push_status_ptr_i = s;
    exp_q.push_back({t, s});
    @(posedge clk_i);
    #1;
    push_i       = 1'b0;
    codma_busy_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (count_o !== CW'(DEPTH) || full_o !== 1'b1 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL launch_push: got count=%0d full=%b ovf=%b required %0d/1/0",
               count_o, full_o, overflow_o, DEPTH);
    end
    @(posedge clk_i);
    #1 codma_irq_i = 1'b1;
    @(negedge clk_i);
    exp_done_count = exp_done_count + 16'd1;
    checks++;
    if (done_o !== 1'b1 || drained_o !== 1'b0) begin
      errors++;
      $display("FAIL launch_push_done: got done=%b drained=%b required 1/0", done_o, drained_o);
    end
    @(posedge clk_i);
    #1;
    codma_irq_i  = 1'b0;
    codma_busy_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) run_task(1 + i, i[0]);
    enable_i = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    do_reset();
    push_task(32'hA0, 32'hB0);
    push_task(32'hA1, 32'hB1);
    enable_i = 1'b1;
    check_launch(ok);
    if (!ok) return;
    for (int i = 1; i < TIMEOUT; i++) begin
      @(negedge clk_i);
      checks++;
      if (error_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early: got %b required 0 at cycle %0d after start", error_o, i);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (error_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_error: got error_o=%b required 1", error_o);
    end
    repeat (10) begin
      @(negedge clk_i);
      checks++;
      if (codma_start_o !== 1'b0 || error_o !== 1'b1) begin
        errors++;
        $display("FAIL error_hold: got start=%b err=%b required 0/1", codma_start_o, error_o);
      end
    end
    checks++;
    if (count_o !== CW'(exp_q.size())) begin
      errors++;
      $display("FAIL error_count: got %0d required %0d", count_o, exp_q.size());
    end
    @(posedge clk_i);
    #1;
    abort_i           = 1'b1;
    push_i            = 1'b1;
    push_task_ptr_i   = $urandom;
    push_status_ptr_i = $urandom;
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    push_i  = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    checks++;
    if (error_o !== 1'b0 || count_o !== '0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_error: got err=%b count=%0d ovf=%b required 0/0/0",
               error_o, count_o, overflow_o);
    end
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if (codma_start_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_start: got %b required 0", codma_start_o);
      end
    end
    enable_i = 1'b0;
  endtask

  task automatic test_abort_run();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) push_task($urandom, $urandom);
    enable_i = 1'b1;
    check_launch(ok);
    if (!ok) return;
    @(posedge clk_i);
    #1 codma_busy_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    abort_i           = 1'b1;
    push_i            = 1'b1;
    push_task_ptr_i   = $urandom;
    push_status_ptr_i = $urandom;
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    push_i  = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    checks++;
    if (codma_stop_o !== 1'b1 || count_o !== '0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_run: got stop=%b count=%0d ovf=%b required 1/0/0",
               codma_stop_o, count_o, overflow_o);
    end
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if (codma_stop_o !== 1'b1 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL stop_hold: got stop=%b done=%b required 1/0", codma_stop_o, done_o);
      end
    end
    @(posedge clk_i);
    #1 codma_busy_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL stop_no_done: got %b required 0", done_o);
    end
    @(negedge clk_i);
    checks++;
    if (codma_stop_o !== 1'b0 || done_count_o !== exp_done_count || codma_start_o !== 1'b0) begin
      errors++;
      $display("FAIL stop_release: got stop=%b done_count=%0d start=%b required 0/%0d/0",
               codma_stop_o, done_count_o, codma_start_o, exp_done_count);
    end
    enable_i = 1'b0;
  endtask

  task automatic test_random();
    int n;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) push_task($urandom, $urandom);
      @(negedge clk_i);
      checks++;
      if (count_o !== CW'(exp_q.size())) begin
        errors++;
        $display("FAIL rand_count: got %0d required %0d", count_o, exp_q.size());
      end
      enable_i = 1'b1;
      for (int i = 0; i < n; i++) run_task($urandom_range(1, 6), 1'($urandom_range(0, 1)));
      enable_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) push_task($urandom | 32'h1, $urandom | 32'h1);
    enable_i = 1'b1;
    run_task(2, 1'b1);
    check_launch(ok);
    if (!ok) return;
    @(posedge clk_i);
    #1 codma_busy_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if ({count_o, full_o, codma_start_o, codma_stop_o, codma_task_ptr_o, codma_status_ptr_o,
         done_o, done_count_o, drained_o, overflow_o, error_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d ovf=%b dc=%0d stop=%b ptr=%h required all 0",
               count_o, overflow_o, done_count_o, codma_stop_o, codma_task_ptr_o);
    end
    @(posedge clk_i);
    #1;
    reset_i      = 1'b0;
    enable_i     = 1'b0;
    codma_busy_i = 1'b0;
    exp_q.delete();
    exp_done_count = '0;
    exp_overflow   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_push_in_launch();
    test_timeout();
    test_abort_run();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_codma_task_sched.md
IP_CODMA_TASK_SCHED -- requirements
Module: ip_codma_task_sched

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  DEPTH, 4, task queue entries (power of 2, 2..16).
  TIMEOUT, 16, max cycles from start to busy before error.
REQ-002 Ports, one per line: name  direction  width  meaning. One clock; reset is asynchronous and active-high.
  clk_i  in  1  clock
  reset_i  in  1  asynchronous active-high reset
  push_i  in  1  enqueue request
  push_task_ptr_i  in  32  task pointer to enqueue
  push_status_ptr_i  in  32  status pointer to enqueue
  enable_i  in  1  permit launching queued tasks
  abort_i  in  1  abort current task, flush queue
  full_o  out  1  queue full
  count_o  out  $clog2(DEPTH+1)  queued entries
  codma_start_o  out  1  start strobe to codma
  codma_stop_o  out  1  stop request to codma
  codma_task_ptr_o  out  32  task pointer to codma
  codma_status_ptr_o  out  32  status pointer to codma
  codma_busy_i  in  1  codma busy
  codma_irq_i  in  1  codma completion interrupt
  done_o  out  1  one-cycle pulse per completed task
  done_count_o  out  16  completed-task counter
  drained_o  out  1  one-cycle pulse when queue empties after a completion
  overflow_o  out  1  sticky, push dropped
  error_o  out  1  sticky, start timeout

Function
REQ-003 Queue SHALL be a FIFO of {task,status} pairs; count_o = entries held; full_o = (count_o == DEPTH).
REQ-004 Push SHALL be accepted when count_o < DEPTH, or when full and a pop occurs in the same cycle; otherwise the push SHALL be dropped and overflow_o set.
REQ-005 Read/write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave count_o unchanged.
REQ-006 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, RUN, STOPPING, ERROR.
REQ-007 IDLE: if enable_i=1, count_o>0 and abort_i=0, next state SHALL be LAUNCH.
REQ-008 LAUNCH (one cycle): codma_task_ptr_o/codma_status_ptr_o SHALL be loaded from the FIFO head on entry; codma_start_o=1 for exactly this cycle; head popped; next WAIT_BUSY.
REQ-009 codma_task_ptr_o/codma_status_ptr_o SHALL be registered and held stable from LAUNCH until the next LAUNCH.
REQ-010 WAIT_BUSY: codma_busy_i=1 SHALL go to RUN; a cycle counter reaching TIMEOUT with busy still 0 SHALL go to ERROR.
REQ-011 RUN: codma_irq_i=1, or codma_busy_i falling to 0, SHALL pulse done_o, increment done_count_o (wraps 0xFFFF->0), and go to IDLE. If count_o is then 0, drained_o SHALL pulse in the same cycle.
REQ-012 Minimum spacing between consecutive codma_start_o pulses SHALL be 3 cycles (LAUNCH, >=1 WAIT_BUSY/RUN, IDLE).
REQ-013 abort_i in WAIT_BUSY or RUN SHALL go to STOPPING. STOPPING: codma_stop_o=1 held until codma_busy_i=0, then go to IDLE. No done_o pulse.
REQ-014 abort_i in any state SHALL flush the FIFO (count_o=0 next cycle). A push in the same cycle as abort_i SHALL be dropped, without setting overflow_o.
REQ-015 ERROR: error_o=1; no launches. Exit to IDLE only on abort_i, which also clears error_o. overflow_o SHALL clear only on reset.
REQ-016 enable_i=0 SHALL block new launches only; a task in flight SHALL complete normally.

Reset
REQ-017 reset_i asserted SHALL asynchronously force IDLE, empty FIFO, and all outputs 0: count_o, full_o, codma_start_o, codma_stop_o, both pointers, done_o, done_count_o, drained_o, overflow_o, error_o.
REQ-018 Reset mid-task SHALL NOT assert codma_stop_o. The codma is reset by its own reset.

Verification
REQ-019 Push 2 tasks (0x100/0x200, 0x300/0x400), enable_i=1, busy high 5 cycles then irq each time -> two start pulses carrying the respective pointers, done_count_o=2, drained_o once after the second task.
REQ-020 Push DEPTH+1 tasks with enable_i=0 -> count_o=4, full_o=1, overflow_o=1, 4th entry intact.
REQ-021 Full queue, push in the LAUNCH cycle -> push accepted, count_o stays 4.
REQ-022 Start issued, busy never rises -> error_o=1 after 16 cycles, no further start; abort_i -> IDLE, error_o=0, count_o=0.
REQ-023 abort_i during RUN with 2 queued -> codma_stop_o held until busy=0, count_o=0, done_count_o unchanged.
REQ-024 reset_i asserted mid-RUN -> all outputs 0 immediately, with no clock edge required.
